ahb_controller: RTL and testbench

- AHB-Lite manager: the initiator end of the bus that ahb_multiplexor routes to the RAM, UART and default satellites.
- Converts the core's instruction-fetch and data-memory request/ready handshakes into single, non-pipelined AHB-Lite transfers.
- Arbitrates between the two core ports, one transfer outstanding at a time.
- Reports completion and error back to the core.

---
 rtl/ahb_controller_if.sv | 38 +++
 rtl/ahb_controller.sv | 139 +++++++++++++
 tb/tb_ahb_controller.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_controller_if.sv
// rtl/ahb_controller_if.sv - core request ports and AHB-Lite manager bus signals
interface ahb_controller_if #(
  parameter int WORD_W = 32
);
  logic              iren;
  logic [WORD_W-1:0] iaddr;
  logic              ihit;
  logic [WORD_W-1:0] iload;

  logic              dren;
  logic              dwen;
  logic [WORD_W-1:0] daddr;
  logic [1:0]        dsize;
  logic [WORD_W-1:0] dstore;
  logic              dhit;
  logic [WORD_W-1:0] dload;
  logic              derr;

  logic [WORD_W-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [2:0]        hburst;
  logic [WORD_W-1:0] hwdata;
  logic [WORD_W-1:0] hrdata;
  logic              hready;
  logic              hresp;

  modport master (
    input  iren, iaddr, dren, dwen, daddr, dsize, dstore, hrdata, hready, hresp,
    output ihit, iload, dhit, dload, derr, haddr, htrans, hwrite, hsize, hburst, hwdata
  );

  modport slave (
    output iren, iaddr, dren, dwen, daddr, dsize, dstore, hrdata, hready, hresp,
    input  ihit, iload, dhit, dload, derr, haddr, htrans, hwrite, hsize, hburst, hwdata
  );
endinterface

// File: rtl/ahb_controller.sv
// rtl/ahb_controller.sv - AHB-Lite manager arbitrating core fetch and data ports
module ahb_controller #(
  parameter int WORD_W = 32,
  parameter bit DPRIO  = 1'b1
) (
  input  logic             clk,
  input  logic             nrst,
  ahb_controller_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_MISAL
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'd2;
  localparam logic [2:0] HBURST_SINGLE = 3'd0;

  state_t            state_q, state_d;
  logic              sel_dport_q, sel_dport_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [2:0]        size_q, size_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;

  logic              drequest;
  logic              pick_dport;
  logic              misaligned;
  logic [1:0]        htrans_c;
  logic              ihit_c, dhit_c, derr_c;
  logic [WORD_W-1:0] iload_c, dload_c, hwdata_c;

  assign drequest   = bus.dren | bus.dwen;
  assign pick_dport = drequest & (DPRIO | ~bus.iren);
  assign misaligned = ((bus.dsize == 2'd1) && bus.daddr[0]) ||
                      ((bus.dsize == 2'd2) && (bus.daddr[1:0] != 2'b00));

  always_comb begin
    state_d     = state_q;
    sel_dport_d = sel_dport_q;
    addr_d      = addr_q;
    write_d     = write_q;
    size_d      = size_q;
    wdata_d     = wdata_q;
    htrans_c    = HTRANS_IDLE;
    ihit_c      = 1'b0;
    dhit_c      = 1'b0;
    derr_c      = 1'b0;
    iload_c     = '0;
    dload_c     = '0;
    hwdata_c    = '0;

    case (state_q)
      ST_IDLE: begin
        if (drequest || bus.iren) begin
          sel_dport_d = pick_dport;
          if (pick_dport) begin
            addr_d  = bus.daddr;
            write_d = bus.dwen;
            size_d  = {1'b0, bus.dsize};
            wdata_d = bus.dwen ? bus.dstore : '0;
            state_d = misaligned ? ST_MISAL : ST_ADDR;
          end else begin
            // Fetches are always word-sized and never alignment-checked.
            addr_d  = bus.iaddr;
            write_d = 1'b0;
            size_d  = HSIZE_WORD;
            wdata_d = '0;
            state_d = ST_ADDR;
          end
        end
      end
      ST_ADDR: begin
        htrans_c = HTRANS_NONSEQ;
        if (bus.hready) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        hwdata_c = wdata_q;
        if (bus.hready) begin
          if (sel_dport_q) begin
            dhit_c  = 1'b1;
            dload_c = bus.hrdata;
            derr_c  = bus.hresp;
          end else begin
            ihit_c  = 1'b1;
            iload_c = bus.hrdata;
          end
          state_d = ST_IDLE;
        end
      end
      ST_MISAL: begin
        dhit_c  = 1'b1;
        derr_c  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q     <= ST_IDLE;
      sel_dport_q <= 1'b0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      size_q      <= HSIZE_WORD;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      sel_dport_q <= sel_dport_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      size_q      <= size_d;
      wdata_q     <= wdata_d;
    end
  end

  // Address-phase signals come straight from the latched request so they hold during ADDR stalls.
  assign bus.haddr  = addr_q;
  assign bus.hwrite = write_q;
  assign bus.hsize  = size_q;
  assign bus.hburst = HBURST_SINGLE;
  assign bus.htrans = htrans_c;
  assign bus.hwdata = hwdata_c;
  assign bus.ihit   = ihit_c;
  assign bus.iload  = iload_c;
  assign bus.dhit   = dhit_c;
  assign bus.dload  = dload_c;
  assign bus.derr   = derr_c;

endmodule

// File: tb/tb_ahb_controller.sv
// tb/tb_ahb_controller.sv - directed vector bench for ahb_controller
module tb_ahb_controller;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  ahb_controller_if #(.WORD_W(32)) bus ();

  ahb_controller #(.WORD_W(32), .DPRIO(1'b1)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus.master)
  );

  typedef struct {
    logic        is_i;
    logic        wr;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] store;
    logic [31:0] rdata;
    int          aw;
    int          waits;
    logic        err;
    int          exp_hit;
    logic        exp_bus;
    logic [2:0]  exp_hsize;
    logic        exp_derr;
  } txn_t;

  txn_t vec [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.iren   = 1'b0;
    bus.dren   = 1'b0;
    bus.dwen   = 1'b0;
    bus.hready = 1'b1;
    bus.hresp  = 1'b0;
  endtask

  task automatic do_txn(input int idx);
    txn_t v;
    int   stalls, k, hit_cyc;
    bit   in_data, seen_bus, accepted;
    v        = vec[idx];
    stalls   = v.aw;
    in_data  = 1'b0;
    seen_bus = 1'b0;
    hit_cyc  = -1;
    k        = 0;
    @(negedge clk);
    bus.iren   = v.is_i;
    bus.iaddr  = v.addr;
    bus.dren   = !v.is_i && !v.wr;
    bus.dwen   = !v.is_i && v.wr;
    bus.daddr  = v.addr;
    bus.dsize  = v.size;
    bus.dstore = v.store;
    bus.hrdata = v.rdata;
    bus.hready = (stalls == 0);
    bus.hresp  = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      #1;
      accepted = 1'b0;
      if (bus.htrans == 2'b10) begin
        seen_bus = 1'b1;
        chk($sformatf("v%0d_haddr", idx), bus.haddr, v.addr);
        chk($sformatf("v%0d_hwrite", idx), {31'b0, bus.hwrite}, {31'b0, v.wr});
        chk($sformatf("v%0d_hsize", idx), {29'b0, bus.hsize}, {29'b0, v.exp_hsize});
        chk($sformatf("v%0d_hburst", idx), {29'b0, bus.hburst}, 32'd0);
        if (bus.hready) accepted = 1'b1;
        else stalls--;
      end
      if (in_data) begin
        chk($sformatf("v%0d_hwdata", idx), bus.hwdata, v.wr ? v.store : 32'd0);
      end
      if (bus.dhit || bus.ihit) begin
        hit_cyc = cyc;
        chk($sformatf("v%0d_ihit", idx), {31'b0, bus.ihit}, {31'b0, v.is_i});
        chk($sformatf("v%0d_dhit", idx), {31'b0, bus.dhit}, {31'b0, !v.is_i});
        chk($sformatf("v%0d_derr", idx), {31'b0, bus.derr}, {31'b0, v.exp_derr});
        if (v.is_i) chk($sformatf("v%0d_iload", idx), bus.iload, v.rdata);
        else if (v.exp_bus) chk($sformatf("v%0d_dload", idx), bus.dload, v.rdata);
        break;
      end else begin
        chk($sformatf("v%0d_quiet_out", idx), bus.iload | bus.dload | {31'b0, bus.derr}, 32'd0);
      end
      @(negedge clk);
      if (accepted) begin
        in_data = 1'b1;
        k       = 0;
      end
      if (in_data) begin
        if (k < v.waits) begin
          bus.hready = 1'b0;
          bus.hresp  = 1'b0;
        end else if (v.err && k == v.waits) begin
          bus.hready = 1'b0;
          bus.hresp  = 1'b1;
        end else begin
          bus.hready = 1'b1;
          bus.hresp  = v.err;
        end
        k++;
      end else begin
        bus.hready = (stalls <= 0);
        bus.hresp  = 1'b0;
      end
    end
    chk($sformatf("v%0d_hit_cycle", idx), hit_cyc, v.exp_hit);
    chk($sformatf("v%0d_bus_used", idx), {31'b0, seen_bus}, {31'b0, v.exp_bus});
    @(negedge clk);
    drive_idle();
    #1;
    chk($sformatf("v%0d_after_htrans", idx), {30'b0, bus.htrans}, 32'd0);
    chk($sformatf("v%0d_after_hit", idx), {30'b0, bus.ihit, bus.dhit}, 32'd0);
  endtask

  initial begin
    int dh, ih, na;
    logic [31:0] ns_addr [2];
    int          ns_cyc  [2];

    //          is_i wr    addr          sz  store         rdata         aw wt err hit bus hsize derr
    vec[0] = '{1'b0, 1'b0, 32'h0000_0100, 2'd2, 32'h0,         32'hDEAD_BEEF, 0, 0, 1'b0, 2, 1'b1, 3'd2, 1'b0};
    vec[1] = '{1'b0, 1'b1, 32'h0002_0004, 2'd2, 32'h0000_0041, 32'h0,         0, 2, 1'b0, 4, 1'b1, 3'd2, 1'b0};
    vec[2] = '{1'b0, 1'b0, 32'h0003_0000, 2'd2, 32'h0,         32'h0BAD_0BAD, 0, 0, 1'b1, 3, 1'b1, 3'd2, 1'b1};
    vec[3] = '{1'b0, 1'b0, 32'h0000_0102, 2'd2, 32'h0,         32'h0,         0, 0, 1'b0, 1, 1'b0, 3'd2, 1'b1};
    vec[4] = '{1'b1, 1'b0, 32'h0000_0200, 2'd2, 32'h0,         32'h0000_0013, 0, 1, 1'b0, 3, 1'b1, 3'd2, 1'b0};
    vec[5] = '{1'b1, 1'b0, 32'h0003_0000, 2'd2, 32'h0,         32'hCAFE_F00D, 0, 0, 1'b1, 3, 1'b1, 3'd2, 1'b0};
    vec[6] = '{1'b0, 1'b0, 32'h0000_0101, 2'd1, 32'h0,         32'h0,         0, 0, 1'b0, 1, 1'b0, 3'd1, 1'b1};
    vec[7] = '{1'b0, 1'b0, 32'h0000_0103, 2'd0, 32'h0,         32'h5500_0000, 2, 0, 1'b0, 4, 1'b1, 3'd0, 1'b0};
    vec[8] = '{1'b0, 1'b1, 32'h0000_0102, 2'd1, 32'h1234_0000, 32'h0,         1, 1, 1'b0, 4, 1'b1, 3'd1, 1'b0};
    vec[9] = '{1'b1, 1'b0, 32'h0000_0102, 2'd2, 32'h0,         32'h8765_4321, 0, 0, 1'b0, 2, 1'b1, 3'd2, 1'b0};

    bus.iaddr  = '0;
    bus.daddr  = '0;
    bus.dsize  = 2'd2;
    bus.dstore = '0;
    bus.hrdata = '0;
    drive_idle();

    repeat (2) @(negedge clk);
    #1;
    chk("rst_htrans", {30'b0, bus.htrans}, 32'd0);
    chk("rst_haddr", bus.haddr, 32'd0);
    chk("rst_hwrite", {31'b0, bus.hwrite}, 32'd0);
    chk("rst_hsize", {29'b0, bus.hsize}, 32'd2);
    chk("rst_hwdata", bus.hwdata, 32'd0);
    chk("rst_hits", {29'b0, bus.ihit, bus.dhit, bus.derr}, 32'd0);
    @(negedge clk);
    nrst = 1'b1;

    for (int i = 0; i < 10; i++) begin
      do_txn(i);
    end

    // Simultaneous fetch and data requests: data port wins, fetch follows.
    @(negedge clk);
    bus.iren   = 1'b1;
    bus.iaddr  = 32'h0000_0040;
    bus.dren   = 1'b1;
    bus.dwen   = 1'b0;
    bus.daddr  = 32'h0000_0100;
    bus.dsize  = 2'd2;
    bus.hrdata = 32'h1111_1111;
    bus.hready = 1'b1;
    bus.hresp  = 1'b0;
    dh = -1;
    ih = -1;
    na = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      #1;
      if (bus.htrans == 2'b10 && na < 2) begin
        ns_addr[na] = bus.haddr;
        ns_cyc[na]  = cyc;
        na++;
      end
      if (bus.dhit && dh < 0) dh = cyc;
      if (bus.ihit && ih < 0) ih = cyc;
      @(negedge clk);
      if (dh >= 0) bus.dren = 1'b0;
      if (ih >= 0) bus.iren = 1'b0;
    end
    chk("arb_nonseq_count", na, 32'd2);
    chk("arb_first_addr", ns_addr[0], 32'h0000_0100);
    chk("arb_first_cyc", ns_cyc[0], 32'd1);
    chk("arb_second_addr", ns_addr[1], 32'h0000_0040);
    chk("arb_second_cyc", ns_cyc[1], 32'd4);
    chk("arb_dhit_cyc", dh, 32'd2);
    chk("arb_ihit_cyc", ih, 32'd5);
    drive_idle();

    // Reset during a stalled data phase abandons the transfer.
    @(negedge clk);
    bus.dren  = 1'b1;
    bus.daddr = 32'h0000_0300;
    bus.dsize = 2'd2;
    @(negedge clk);
    #1;
    chk("rst_mid_addr_phase", {30'b0, bus.htrans}, 32'h2);
    @(negedge clk);
    bus.hready = 1'b0;
    #1;
    chk("rst_mid_no_hit_stall", {30'b0, bus.ihit, bus.dhit}, 32'd0);
    nrst = 1'b0;
    @(negedge clk);
    nrst     = 1'b1;
    bus.dren = 1'b0;
    bus.hready = 1'b1;
    #1;
    chk("rst_mid_htrans", {30'b0, bus.htrans}, 32'd0);
    chk("rst_mid_no_hit", {30'b0, bus.ihit, bus.dhit}, 32'd0);
    chk("rst_mid_haddr", bus.haddr, 32'd0);
    chk("rst_mid_hsize", {29'b0, bus.hsize}, 32'd2);
    @(negedge clk);
    #1;
    chk("rst_mid_still_idle", {30'b0, bus.htrans}, 32'd0);
    do_txn(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
